// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types.
//   word_t       - 32-bit machine word
//   ramstate_t   - status reported by the unified RAM
//   arb_state_t  - memory_arbiter grant state
//   ARB_STREAK_W - width of the arbiter's data-grant streak counter
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    localparam int ARB_STREAK_W = 4;

    // The RAM finishes an access on ACCESS or ERROR; ERROR still retires it.
    function automatic logic ram_done(ramstate_t s);
        return (s == ACCESS) || (s == ERROR);
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: bundle of the arbiter's requester-side and RAM-side signals.
//   modport ma - the arbiter block
//   modport tb - the environment driving requests and modelling the RAM
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      iwait, dwait;
    word_t     iload, dload;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    logic      ramerr;

    modport ma (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: single-port RAM arbiter between instruction fetch and data memory.
// Data has priority; after MAX_DSTREAK consecutive data grants with a fetch
// pending, the fetch is forced through. Each completion is followed by a one-cycle
// GAP so requesters get an edge to retire or update their request.
//   CLK, RST           - clock, asynchronous active-high reset
//   iREN, iaddr        - fetch request / address;   iwait, iload  - fetch status / data
//   dREN, dWEN, daddr, dstore - data request;      dwait, dload  - data status / data
//   ramREN, ramWEN, ramaddr, ramstore - RAM strobes (combinational from state + requests)
//   ramload, ramstate  - RAM read data / status
//   ramerr             - sticky flag, set by any ERROR completion
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ramerr
);

    localparam logic [ARB_STREAK_W-1:0] DLIM = ARB_STREAK_W'(MAX_DSTREAK);

    arb_state_t              state;
    logic [ARB_STREAK_W-1:0] streak;
    logic                    dreq;
    logic                    fin;
    logic                    i_done;
    logic                    d_done;

    assign dreq = dREN | dWEN;
    assign fin  = ram_done(ramstate_t'(ramstate));

    // RAM side and wait/load outputs. A withdrawn request drops its strobe in
    // the same cycle because the strobes follow the live request, not the state.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = dreq;
        iload    = '0;
        dload    = '0;
        i_done   = 1'b0;
        d_done   = 1'b0;
        case (state)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                i_done  = iREN & fin;
                iwait   = iREN & ~i_done;
                if (i_done) iload = ramload;
            end
            DGNT: begin
                // write wins when both data strobes are up
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                d_done   = dreq & fin;
                dwait    = dreq & ~d_done;
                if (d_done) dload = ramload;
            end
            GAP: begin
                iwait = 1'b1;
                dwait = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            streak <= '0;
            ramerr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq && (!iREN || streak < DLIM)) state <= DGNT;
                    else if (iREN)                        state <= IGNT;
                end
                IGNT: begin
                    if (!iREN) begin
                        state <= IDLE;
                    end else if (i_done) begin
                        state  <= GAP;
                        streak <= '0;
                        if (ramstate_t'(ramstate) == ERROR) ramerr <= 1'b1;
                    end
                end
                DGNT: begin
                    if (!dreq) begin
                        state <= IDLE;
                    end else if (d_done) begin
                        state <= GAP;
                        // streak only counts data wins over a waiting fetch
                        if (!iREN)                streak <= '0;
                        else if (streak != '1)    streak <= streak + 1'b1;
                        if (ramstate_t'(ramstate) == ERROR) ramerr <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int MAXD = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, ramerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    memory_arbiter #(.MAX_DSTREAK(MAXD)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 32'h40; daddr = 32'h100; dstore = 0; ramload = 0; ramstate = FREE;
    endtask

    task automatic do_reset();
        nxt(); RST = 1; idle_inputs();
        nxt(); RST = 0;
    endtask

    typedef struct {
        logic        rst, iren, dren, dwen;
        logic [31:0] ia, da, ds, rl;
        logic [1:0]  rs;
        logic        iw, dw, ren, wen;
        logic [31:0] addr, il, dl;
    } vec_t;

    vec_t tbl[13];

    // random-phase reference model
    int   m_own;   // 0 none, 1 fetch, 2 data
    bit   m_gap;
    int   m_str;
    bit   m_err;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq[6];
        logic [7:0] exp_seq[6];
        int         n;

        RST = 1; idle_inputs();

        //          rst i d w  ia     da      ds rl            rs      iw dw ren wen addr    il            dl
        tbl[0]  = '{1,1,0,0, 32'h40, 32'h100, 0, 0,            FREE,   1, 0, 0, 0, 0,      0,            0};
        tbl[1]  = '{0,1,0,0, 32'h40, 32'h100, 0, 0,            FREE,   1, 0, 0, 0, 0,      0,            0};
        tbl[2]  = '{0,1,0,0, 32'h40, 32'h100, 0, 0,            BUSY,   1, 0, 1, 0, 32'h40, 0,            0};
        tbl[3]  = '{0,1,0,0, 32'h40, 32'h100, 0, 0,            BUSY,   1, 0, 1, 0, 32'h40, 0,            0};
        tbl[4]  = '{0,1,0,0, 32'h40, 32'h100, 0, 32'h8C220004, ACCESS, 0, 0, 1, 0, 32'h40, 32'h8C220004, 0};
        tbl[5]  = '{0,1,1,0, 32'h40, 32'h100, 0, 32'h8C220004, ACCESS, 1, 1, 0, 0, 0,      0,            0};
        tbl[6]  = '{0,1,1,0, 32'h40, 32'h100, 0, 0,            BUSY,   1, 1, 0, 0, 0,      0,            0};
        tbl[7]  = '{0,1,1,0, 32'h40, 32'h100, 0, 32'h1234,     ACCESS, 1, 0, 1, 0, 32'h100,0,            32'h1234};
        tbl[8]  = '{0,1,0,0, 32'h40, 32'h100, 0, 32'h1234,     ACCESS, 1, 1, 0, 0, 0,      0,            0};
        tbl[9]  = '{0,1,0,0, 32'h40, 32'h100, 0, 0,            FREE,   1, 0, 0, 0, 0,      0,            0};
        tbl[10] = '{0,1,0,0, 32'h40, 32'h100, 0, 32'hAA,       ACCESS, 0, 0, 1, 0, 32'h40, 32'hAA,       0};
        tbl[11] = '{0,0,0,0, 32'h40, 32'h100, 0, 0,            FREE,   1, 1, 0, 0, 0,      0,            0};
        tbl[12] = '{0,0,0,0, 32'h40, 32'h100, 0, 0,            FREE,   0, 0, 0, 0, 0,      0,            0};

        for (int i = 0; i < 13; i++) begin
            nxt();
            RST = tbl[i].rst; iREN = tbl[i].iren; dREN = tbl[i].dren; dWEN = tbl[i].dwen;
            iaddr = tbl[i].ia; daddr = tbl[i].da; dstore = tbl[i].ds;
            ramload = tbl[i].rl; ramstate = tbl[i].rs;
            smp();
            chk($sformatf("tbl%0d iwait", i), iwait, tbl[i].iw);
            chk($sformatf("tbl%0d dwait", i), dwait, tbl[i].dw);
            chk($sformatf("tbl%0d ramREN", i), ramREN, tbl[i].ren);
            chk($sformatf("tbl%0d ramWEN", i), ramWEN, tbl[i].wen);
            chk($sformatf("tbl%0d ramaddr", i), ramaddr, tbl[i].addr);
            chk($sformatf("tbl%0d iload", i), iload, tbl[i].il);
            chk($sformatf("tbl%0d dload", i), dload, tbl[i].dl);
            if (i == 0) chk("reset ramerr", ramerr, 0);
        end

        // starvation bound: continuous fetch + data, RAM always ready
        do_reset();
        iREN = 1; dREN = 1; ramstate = ACCESS;
        exp_seq[0] = "D"; exp_seq[1] = "D"; exp_seq[2] = "I";
        exp_seq[3] = "D"; exp_seq[4] = "D"; exp_seq[5] = "I";
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            smp();
            if (ramREN && !dwait) begin seq[n] = "D"; n++; end
            else if (ramREN && !iwait) begin seq[n] = "I"; n++; end
            nxt();
        end
        chk("streak grant count", n, 6);
        for (int k = 0; k < n; k++) chk($sformatf("streak grant%0d", k), seq[k], exp_seq[k]);

        // write ending in ERROR: sticky ramerr
        do_reset();
        dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramstate = BUSY;
        smp(); chk("err idle dwait", dwait, 1); chk("err idle wen", ramWEN, 0);
        nxt(); smp();
        chk("err wen", ramWEN, 1); chk("err addr", ramaddr, 32'h200);
        chk("err store", ramstore, 32'hDEADBEEF); chk("err busy dwait", dwait, 1);
        nxt(); ramstate = ERROR; smp();
        chk("err done wen", ramWEN, 1); chk("err done dwait", dwait, 0); chk("err pre flag", ramerr, 0);
        nxt(); dWEN = 0; ramstate = FREE; smp();
        chk("err gap wen", ramWEN, 0); chk("err flag", ramerr, 1);
        for (int c = 0; c < 3; c++) begin nxt(); smp(); chk("err sticky", ramerr, 1); end
        nxt(); RST = 1; smp(); chk("err cleared by reset", ramerr, 0);
        nxt(); RST = 0;

        // withdrawal mid-grant leaves streak alone
        do_reset();
        iREN = 1; dREN = 1; ramstate = ACCESS;
        smp();                        // IDLE
        nxt(); smp(); chk("wd first done", dwait, 0);   // DGNT, streak -> 1
        nxt(); ramstate = BUSY; smp(); // GAP
        nxt(); smp();                 // IDLE -> DGNT
        nxt(); smp(); chk("wd busy ren", ramREN, 1); chk("wd busy addr", ramaddr, 32'h100);
        nxt(); dREN = 0; smp();
        chk("wd drop ren", ramREN, 0); chk("wd drop wen", ramWEN, 0);
        chk("wd drop dwait", dwait, 0); chk("wd drop iwait", iwait, 1);
        nxt(); dREN = 1; smp(); chk("wd idle ren", ramREN, 0);
        nxt(); smp(); chk("wd regrant data ren", ramREN, 1); chk("wd regrant data addr", ramaddr, 32'h100);

        // reset asserted mid-grant
        do_reset();
        iREN = 1; iaddr = 32'h80; ramstate = BUSY;
        smp();
        nxt(); smp(); chk("rst grant ren", ramREN, 1); chk("rst grant addr", ramaddr, 32'h80);
        nxt(); RST = 1; ramstate = ACCESS; ramload = 32'hFFFF; smp();
        chk("rst mid ren", ramREN, 0); chk("rst mid iwait", iwait, 1); chk("rst mid iload", iload, 0);
        nxt(); RST = 0; smp(); chk("rst release ren", ramREN, 0);
        nxt(); smp(); chk("rst regrant ren", ramREN, 1);

        // randomized run against the reference model
        do_reset();
        m_own = 0; m_gap = 0; m_str = 0; m_err = 0;
        for (int c = 0; c < 3000; c++) begin
            bit dq, fin, done, idle_like;
            bit e_iw, e_dw, e_ren, e_wen;
            logic [31:0] e_il, e_dl;
            nxt();
            RST = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) iREN = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) dREN = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) dWEN = $urandom_range(0, 1);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            smp();

            dq = dREN | dWEN;
            fin = (ramstate == ACCESS) || (ramstate == ERROR);
            done = 0; idle_like = 1;
            e_iw = iREN; e_dw = dq; e_ren = 0; e_wen = 0; e_il = 0; e_dl = 0;
            if (RST) begin
                m_own = 0; m_gap = 0; m_str = 0; m_err = 0;
            end else if (m_gap) begin
                e_iw = 1; e_dw = 1;
            end else if (m_own == 1) begin
                idle_like = 0;
                e_ren = iREN; done = iREN && fin;
                e_iw = iREN && !done;
                if (done) e_il = ramload;
            end else if (m_own == 2) begin
                idle_like = 0;
                e_wen = dWEN; e_ren = dREN && !dWEN; done = dq && fin;
                e_dw = dq && !done;
                if (done) e_dl = ramload;
            end

            chk("rnd iwait", iwait, e_iw);
            chk("rnd dwait", dwait, e_dw);
            chk("rnd ramREN", ramREN, e_ren);
            chk("rnd ramWEN", ramWEN, e_wen);
            chk("rnd iload", iload, e_il);
            chk("rnd dload", dload, e_dl);
            chk("rnd ramerr", ramerr, m_err);
            if (idle_like) begin
                chk("rnd idle addr", ramaddr, 0);
                chk("rnd idle store", ramstore, 0);
            end else if (e_ren || e_wen) begin
                chk("rnd addr", ramaddr, (m_own == 1) ? iaddr : daddr);
                if (e_wen) chk("rnd store", ramstore, dstore);
            end

            // advance the model to the next cycle
            if (RST) begin
                m_own = 0; m_gap = 0; m_str = 0; m_err = 0;
            end else if (m_gap) begin
                m_gap = 0;
            end else if (m_own == 1) begin
                if (!iREN) m_own = 0;
                else if (done) begin
                    m_str = 0; m_own = 0; m_gap = 1;
                    if (ramstate == ERROR) m_err = 1;
                end
            end else if (m_own == 2) begin
                if (!dq) m_own = 0;
                else if (done) begin
                    m_str = iREN ? ((m_str < 15) ? m_str + 1 : 15) : 0;
                    m_own = 0; m_gap = 1;
                    if (ramstate == ERROR) m_err = 1;
                end
            end else begin
                if (dq && (!iREN || m_str < MAXD)) m_own = 2;
                else if (iREN) m_own = 1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
